clsf_vec_assembler: RTL and testbench
=====================================

Name: clsf_vec_assembler

Overview:
- Upstream stage of clsf_tree.
- Drains 32-bit feature words from the rx FIFO (first-word-tagged with SOF), packs 54 consecutive words into one 1728-bit feature vector, and presents it to the tree bank with a single-cycle data_valid pulse.
- Enforces frame alignment: words arriving before a SOF are discarded, and frames truncated by an early SOF are counted as errors.

Parameters:
- WORD_W, 32, FIFO word width.
- WORDS, 54, words per feature vector.
- VEC_W, 1728, vector width; must equal WORD_W*WORDS.
- ERR_W, 16, width of the error counter.

Ports:
- rx_fifo_clock  in  1  single clock for the block.
- rx_fifo_reset  in  1  reset; synchronous, active-high.
- enable  in  1  allows FIFO reads when high.
- fifo_empty  in  1  rx FIFO empty flag.
- fifo_rd_en  out  1  FIFO read strobe.
- fifo_dout  in  WORD_W  FIFO read data; valid one cycle after fifo_rd_en.
- fifo_sof  in  1  start-of-frame tag; travels with fifo_dout, same cycle.
- data_out  out  VEC_W  assembled feature vector, connected to clsf_tree data_in.
- data_valid  out  1  one-cycle pulse when data_out is updated.
- frame_err  out  1  one-cycle pulse on a truncated frame.
- err_count  out  ERR_W  saturating count of frame_err pulses.
- busy  out  1  high while in FILL.

Behaviour:
- Reset: all outputs are 0, including data_out and err_count. state=IDLE, word count=0, rd_vld=0. The reset overrides all other events in that cycle.
- Reset mid-frame: the partial frame is discarded. No data_valid and no frame_err are issued for it.
- fifo_rd_en is combinational: enable & ~fifo_empty & ~rx_fifo_reset. This is the only way the block reads the FIFO.
- rd_vld is fifo_rd_en registered. A word is "returned" in a cycle where rd_vld=1, and fifo_dout/fifo_sof are sampled only in that cycle.
- Dropping enable stops new reads. A word already in flight (rd_vld=1) is still consumed.
- State IDLE:
  - A returned word with sof=0 is discarded silently.
  - A returned word with sof=1 is stored to slot 0; count<=1; state<=FILL.
- State FILL:
  - Returned word with sof=0 and count<WORDS-1: stored to slot count; count<=count+1.
  - Returned word with sof=0 and count==WORDS-1: last word. The next cycle shows data_out = {word, slots[WORDS-2:0]} and data_valid=1 for one cycle. state<=IDLE; count<=0.
  - Returned word with sof=1: early SOF. Next cycle frame_err=1 for one cycle and err_count increments, saturating at all-ones. This word restarts the frame: slot 0, count<=1, state stays FILL. No data_valid is issued for the truncated frame.
- Packing: slot i occupies data_out[i*WORD_W +: WORD_W]. The first word is the LSBs, the last word is the MSBs.
- data_out changes only in the cycle where data_valid=1 and holds its value otherwise. The slot buffer is separate from data_out, so filling the next frame never disturbs the held vector.
- Latency: data_valid is 1 cycle after the last word's return, i.e. 2 cycles after its fifo_rd_en.
- Throughput: one vector per WORDS cycles with the FIFO never empty. A new SOF may be returned in the same cycle that data_valid pulses.
- Empty FIFO gaps inside a frame are legal. The frame simply stalls; there is no timeout.
- busy=1 exactly when state==FILL.

Decomposition:
- Shared package clsf_pkg holds WORD_W, WORDS, VEC_W (also used by clsf_tree and the lut trees), the state enum {IDLE, FILL}, and ERR_W.
- One natural sub-module, clsf_err_cnt: a saturating counter with an inc pulse input and a synchronous reset.
- The slot buffer and the FSM stay in the top level.

Test Plan:
- Reset then a full frame: FIFO holds 54 words 0x00000001..0x00000036, SOF on the first word, enable=1 → one data_valid pulse, 2 cycles after the 54th rd_en; data_out[31:0]=0x1; data_out[1727:1696]=0x36; frame_err never asserted.
- Pre-SOF garbage: 3 words with sof=0, then a valid 54-word frame → the garbage is dropped; data_out is identical to the first case; exactly one data_valid.
- Early SOF: SOF frame of 20 words, then a new SOF frame of 54 words → frame_err pulses once, err_count=1; one data_valid whose slot 0 is the second SOF word.
- Stalls: fifo_empty toggled every other cycle and enable low for 10 cycles mid-frame → the correct vector is still produced; no read occurs while enable=0 except the one in-flight word; data_out holds its previous value until the new data_valid.
- Back-to-back frames: two frames with no gap → data_valid pulses are exactly 54 cycles apart; the second vector does not corrupt the first before its pulse.
- Reset mid-frame and saturation: assert rx_fifo_reset after word 30 → all outputs return to 0, with no data_valid and no frame_err. Separately, with ERR_W forced to 2, 5 truncated frames → err_count saturates at 3.

Source files
------------

// File: rtl/clsf_pkg.sv
// Shared definitions for the classifier datapath: feature word/vector geometry,
// error counter width and the vector assembler state encoding.
package clsf_pkg;

    localparam int WORD_W = 32;
    localparam int WORDS  = 54;
    localparam int VEC_W  = WORD_W * WORDS;
    localparam int ERR_W  = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

endpackage

// File: rtl/clsf_err_cnt.sv
// Saturating event counter: counts single-cycle inc pulses and sticks at
// all-ones instead of wrapping, so a flood of errors never reads as few.
module clsf_err_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_r;

    // Count register with synchronous clear and saturation at all-ones.
    always_ff @(posedge clk) begin
        if (srst) begin
            count_r <= {W{1'b0}};
        end else if (inc && (count_r != {W{1'b1}})) begin
            count_r <= count_r + W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/clsf_vec_assembler.sv
// Feature vector assembler: reads SOF-tagged words from the rx FIFO, packs
// WORDS consecutive words (first word in the LSBs) into one vector and
// pulses data_valid when the vector is presented. Words before a SOF are
// dropped; a SOF arriving mid-frame restarts the frame and flags an error.
module clsf_vec_assembler #(
    parameter int WORD_W = clsf_pkg::WORD_W,
    parameter int WORDS  = clsf_pkg::WORDS,
    parameter int VEC_W  = clsf_pkg::VEC_W,
    parameter int ERR_W  = clsf_pkg::ERR_W
) (
    input  logic              rx_fifo_clock,
    input  logic              rx_fifo_reset,
    input  logic              enable,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [WORD_W-1:0] fifo_dout,
    input  logic              fifo_sof,
    output logic [VEC_W-1:0]  data_out,
    output logic              data_valid,
    output logic              frame_err,
    output logic [ERR_W-1:0]  err_count,
    output logic              busy
);

    import clsf_pkg::*;

    localparam int               CNT_W    = $clog2(WORDS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS - 1);

    state_t             state_r;
    state_t             state_nxt_s;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   count_nxt_s;
    logic               rd_vld_r;

    // Slots 0..WORDS-2 are buffered; the last word goes straight to data_out.
    logic [WORD_W-1:0]  slot_r [WORDS-1];
    logic               slot_we_s;
    logic [CNT_W-1:0]   slot_idx_s;

    logic               vec_load_s;
    logic               early_sof_s;
    logic [VEC_W-1:0]   data_out_r;
    logic               data_valid_r;
    logic               frame_err_r;
    logic [ERR_W-1:0]   err_count_s;

    // Reads are never issued while reset is held, so nothing is lost on release.
    assign fifo_rd_en = enable & ~fifo_empty & ~rx_fifo_reset;

    // Next-state logic: decide what to do with the word returned this cycle.
    always_comb begin
        state_nxt_s = state_r;
        count_nxt_s = count_r;
        slot_we_s   = 1'b0;
        slot_idx_s  = {CNT_W{1'b0}};
        vec_load_s  = 1'b0;
        early_sof_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (rd_vld_r && fifo_sof) begin
                    slot_we_s   = 1'b1;
                    slot_idx_s  = {CNT_W{1'b0}};
                    count_nxt_s = CNT_W'(1);
                    state_nxt_s = FILL;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            FILL: begin
                if (rd_vld_r) begin
                    if (fifo_sof) begin
                        // Truncated frame: this SOF word becomes slot 0 of a new frame.
                        early_sof_s = 1'b1;
                        slot_we_s   = 1'b1;
                        slot_idx_s  = {CNT_W{1'b0}};
                        count_nxt_s = CNT_W'(1);
                    end else if (count_r == LAST_IDX) begin
                        vec_load_s  = 1'b1;
                        count_nxt_s = {CNT_W{1'b0}};
                        state_nxt_s = IDLE;
                    end else begin
                        slot_we_s   = 1'b1;
                        slot_idx_s  = count_r;
                        count_nxt_s = count_r + CNT_W'(1);
                    end
                end else begin
                    state_nxt_s = FILL;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                count_nxt_s = {CNT_W{1'b0}};
            end
        endcase
    end

    // Control state: FSM, word count, read-return flag and output pulses.
    always_ff @(posedge rx_fifo_clock) begin
        if (rx_fifo_reset) begin
            state_r      <= IDLE;
            count_r      <= {CNT_W{1'b0}};
            rd_vld_r     <= 1'b0;
            data_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            count_r      <= count_nxt_s;
            rd_vld_r     <= fifo_rd_en;
            data_valid_r <= vec_load_s;
            frame_err_r  <= early_sof_s;
        end
    end

    // Slot buffer write; contents are always overwritten before being used.
    always_ff @(posedge rx_fifo_clock) begin
        if (!rx_fifo_reset && slot_we_s) begin
            slot_r[slot_idx_s] <= fifo_dout;
        end
    end

    // Output vector: loaded only on frame completion, held otherwise.
    always_ff @(posedge rx_fifo_clock) begin
        if (rx_fifo_reset) begin
            data_out_r <= {VEC_W{1'b0}};
        end else if (vec_load_s) begin
            for (int i = 0; i < WORDS - 1; i++) begin
                data_out_r[i*WORD_W +: WORD_W] <= slot_r[i];
            end
            data_out_r[VEC_W-1 -: WORD_W] <= fifo_dout;
        end else begin
            data_out_r <= data_out_r;
        end
    end

    clsf_err_cnt #(
        .W (ERR_W)
    ) u_err_cnt (
        .clk   (rx_fifo_clock),
        .srst  (rx_fifo_reset),
        .inc   (early_sof_s),
        .count (err_count_s)
    );

    assign data_out   = data_out_r;
    assign data_valid = data_valid_r;
    assign frame_err  = frame_err_r;
    assign err_count  = err_count_s;
    assign busy       = (state_r == FILL);

endmodule

// File: tb/tb_clsf_vec_assembler.sv
// Scoreboard bench for clsf_vec_assembler: a FIFO model feeds tagged words,
// stimulus pushes expected vectors/error counts, a monitor compares on output.
module tb_clsf_vec_assembler;

    import clsf_pkg::*;

    logic                clk           = 1'b0;
    logic                rx_fifo_reset = 1'b1;
    logic                enable        = 1'b0;
    logic                fifo_empty    = 1'b1;
    logic                fifo_rd_en;
    logic [WORD_W-1:0]   fifo_dout     = '0;
    logic                fifo_sof      = 1'b0;
    logic [VEC_W-1:0]    data_out;
    logic                data_valid;
    logic                frame_err;
    logic [ERR_W-1:0]    err_count;
    logic                busy;

    logic                rd_en_sat;
    logic [VEC_W-1:0]    data_out_sat;
    logic                data_valid_sat;
    logic                frame_err_sat;
    logic [1:0]          err_count_sat;
    logic                busy_sat;

    typedef struct packed {
        logic              sof;
        logic [WORD_W-1:0] d;
        logic              last;
    } ent_t;

    typedef struct packed {
        logic [ERR_W-1:0] main;
        logic [1:0]       sat;
    } err_t;

    ent_t             fifo_q[$];
    err_t             exp_err_q[$];
    logic [VEC_W-1:0] exp_vec_q[$];
    int               last_cyc_q[$];
    int               dv_cyc_q[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int rd_words = 0;
    int err_n    = 0;
    bit mon_on   = 1'b0;
    bit gap_mode = 1'b0;

    always #5 clk = ~clk;

    clsf_vec_assembler u_dut (
        .rx_fifo_clock (clk),
        .rx_fifo_reset (rx_fifo_reset),
        .enable        (enable),
        .fifo_empty    (fifo_empty),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_dout     (fifo_dout),
        .fifo_sof      (fifo_sof),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .frame_err     (frame_err),
        .err_count     (err_count),
        .busy          (busy)
    );

    // Same stimulus, 2-bit error counter to exercise saturation.
    clsf_vec_assembler #(.ERR_W(2)) u_dut_sat (
        .rx_fifo_clock (clk),
        .rx_fifo_reset (rx_fifo_reset),
        .enable        (enable),
        .fifo_empty    (fifo_empty),
        .fifo_rd_en    (rd_en_sat),
        .fifo_dout     (fifo_dout),
        .fifo_sof      (fifo_sof),
        .data_out      (data_out_sat),
        .data_valid    (data_valid_sat),
        .frame_err     (frame_err_sat),
        .err_count     (err_count_sat),
        .busy          (busy_sat)
    );

    // FIFO model: one-cycle read latency, registered empty flag, optional gaps.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rx_fifo_reset) begin
            fifo_q.delete();
            fifo_empty <= 1'b1;
        end else begin
            if (fifo_rd_en && (fifo_q.size() > 0)) begin
                fifo_sof  <= fifo_q[0].sof;
                fifo_dout <= fifo_q[0].d;
                if (fifo_q[0].last) last_cyc_q.push_back(cyc);
                void'(fifo_q.pop_front());
                rd_words <= rd_words + 1;
            end
            fifo_empty <= (fifo_q.size() == 0) || (gap_mode && !fifo_empty);
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    task automatic vec_check(input string nm, input logic [VEC_W-1:0] act, input logic [VEC_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            for (int i = 0; i < WORDS; i++) begin
                if (act[i*WORD_W +: WORD_W] !== exp[i*WORD_W +: WORD_W]) begin
                    $display("FAIL %s slot=%0d actual=0x%0h required=0x%0h", nm, i,
                             act[i*WORD_W +: WORD_W], exp[i*WORD_W +: WORD_W]);
                    break;
                end
            end
        end
    endtask

    // Monitor: compare every output event against the scoreboard queues.
    initial begin
        logic [VEC_W-1:0] last_vec;
        logic [VEC_W-1:0] ev;
        err_t             ee;
        last_vec = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mon_on) begin
                if (rx_fifo_reset) last_vec = '0;
                if (data_valid) begin
                    if (exp_vec_q.size() == 0) begin
                        check("unexpected_data_valid", 64'd1, 64'd0);
                    end else begin
                        ev = exp_vec_q.pop_front();
                        vec_check("vector", data_out, ev);
                        if (last_cyc_q.size() > 0)
                            check("latency", 64'(cyc - last_cyc_q.pop_front()), 64'd2);
                        else
                            check("latency_no_last_read", 64'd0, 64'd1);
                    end
                    last_vec = data_out;
                    dv_cyc_q.push_back(cyc);
                end else begin
                    vec_check("data_out_hold", data_out, last_vec);
                end
                if (frame_err) begin
                    if (exp_err_q.size() == 0) begin
                        check("unexpected_frame_err", 64'd1, 64'd0);
                    end else begin
                        ee = exp_err_q.pop_front();
                        check("err_count", 64'(err_count), 64'(ee.main));
                        check("err_count_sat", 64'(err_count_sat), 64'(ee.sat));
                    end
                end
                if (!enable) check("rd_while_disabled", 64'(fifo_rd_en), 64'd0);
            end
        end
    end

    task automatic push_frame(input logic [WORD_W-1:0] base, input int n, input bit complete);
        ent_t             e;
        logic [VEC_W-1:0] v;
        v = '0;
        for (int i = 0; i < n; i++) begin
            e.sof  = (i == 0);
            e.d    = base + WORD_W'(i);
            e.last = complete && (i == n - 1);
            fifo_q.push_back(e);
            if (i < WORDS) v[i*WORD_W +: WORD_W] = base + WORD_W'(i);
        end
        if (complete) exp_vec_q.push_back(v);
    endtask

    task automatic push_garbage(input int n);
        ent_t e;
        for (int i = 0; i < n; i++) begin
            e.sof  = 1'b0;
            e.d    = 32'hDEAD_0000 + WORD_W'(i);
            e.last = 1'b0;
            fifo_q.push_back(e);
        end
    endtask

    task automatic expect_err();
        err_t e;
        err_n++;
        e.main = (err_n > 65535) ? 16'hFFFF : 16'(err_n);
        e.sat  = (err_n > 3) ? 2'd3 : 2'(err_n);
        exp_err_q.push_back(e);
    endtask

    task automatic wait_done(input string nm, input int budget);
        int n;
        n = 0;
        while ((fifo_q.size() != 0 || exp_vec_q.size() != 0 || exp_err_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_drained"}, 64'(fifo_q.size() + exp_vec_q.size() + exp_err_q.size()), 64'd0);
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_words(input int target, input int budget);
        int n;
        n = 0;
        while (rd_words < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("words_read_bound", 64'(rd_words >= target), 64'd1);
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_data_out"},   64'(data_out == '0), 64'd1);
        check({nm, "_data_valid"}, 64'(data_valid), 64'd0);
        check({nm, "_frame_err"},  64'(frame_err), 64'd0);
        check({nm, "_err_count"},  64'(err_count), 64'd0);
        check({nm, "_err_sat"},    64'(err_count_sat), 64'd0);
        check({nm, "_busy"},       64'(busy), 64'd0);
        check({nm, "_rd_en"},      64'(fifo_rd_en), 64'd0);
    endtask

    // Directed test sequence.
    initial begin
        int start;
        enable        = 1'b1;
        rx_fifo_reset = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rx_fifo_reset = 1'b0;
        mon_on        = 1'b1;

        // Full frame 0x1..0x36.
        push_frame(32'h0000_0001, WORDS, 1'b1);
        wait_done("t1", 500);
        check("t1_lsw", 64'(data_out[31:0]), 64'h1);
        check("t1_msw", 64'(data_out[1727:1696]), 64'h36);
        check("t1_busy_idle", 64'(busy), 64'd0);

        // Garbage before SOF, then same frame.
        dv_cyc_q.delete();
        push_garbage(3);
        push_frame(32'h0000_0001, WORDS, 1'b1);
        wait_done("t2", 500);
        check("t2_dv_count", 64'(dv_cyc_q.size()), 64'd1);

        // Early SOF truncates a 20-word frame.
        push_frame(32'h0000_0100, 20, 1'b0);
        wait_words(rd_words + 20, 200);
        repeat (2) @(negedge clk);
        check("t3_busy_partial", 64'(busy), 64'd1);
        expect_err();
        push_frame(32'h0000_0200, WORDS, 1'b1);
        wait_done("t3", 500);
        check("t3_err_count", 64'(err_count), 64'd1);
        check("t3_slot0", 64'(data_out[31:0]), 64'h200);

        // Stalls: gapped FIFO plus enable dropped for 10 cycles mid-frame.
        gap_mode = 1'b1;
        start    = rd_words;
        push_frame(32'h0000_0300, WORDS, 1'b1);
        wait_words(start + 20, 200);
        enable = 1'b0;
        repeat (10) @(negedge clk);
        check("t4_stalled_reads", 64'(rd_words - start), 64'd20);
        enable = 1'b1;
        wait_done("t4", 800);
        gap_mode = 1'b0;

        // Back-to-back frames.
        dv_cyc_q.delete();
        push_frame(32'h0000_0400, WORDS, 1'b1);
        push_frame(32'h0000_0500, WORDS, 1'b1);
        wait_done("t5", 800);
        check("t5_dv_count", 64'(dv_cyc_q.size()), 64'd2);
        if (dv_cyc_q.size() == 2)
            check("t5_dv_spacing", 64'(dv_cyc_q[1] - dv_cyc_q[0]), 64'd54);

        // Reset after word 30 of a frame.
        start = rd_words;
        push_frame(32'h0000_0600, 40, 1'b0);
        wait_words(start + 30, 200);
        check("t6_busy_before", 64'(busy), 64'd1);
        rx_fifo_reset = 1'b1;
        err_n         = 0;
        @(negedge clk);
        check_all_zero("t6_reset");
        @(negedge clk);
        rx_fifo_reset = 1'b0;
        repeat (80) @(negedge clk);
        check("t6_busy_after", 64'(busy), 64'd0);
        check("t6_data_out_zero", 64'(data_out == '0), 64'd1);

        // Five truncated frames, then a complete one.
        for (int k = 0; k < 5; k++) begin
            push_frame(32'h0000_0700 + WORD_W'(k * 16), 3, 1'b0);
            expect_err();
        end
        push_frame(32'h0000_0800, WORDS, 1'b1);
        wait_done("t7", 800);
        check("t7_err_count", 64'(err_count), 64'd5);
        check("t7_err_sat", 64'(err_count_sat), 64'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
